// File: rtl/restoring_divider_ctrl.sv
// Sequential unsigned restoring divider: one trial subtraction per cycle on a
// shared add/sub instance, start/busy/done handshake, registered results.

module full_adder_subtrator #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] s,
   output logic             cout
);

   logic [WIDTH:0] sum_s;

   // cin=1 inverts b and adds one, so cout=1 means no borrow (a >= b)
   assign sum_s = {1'b0, a} + {1'b0, b ^ {WIDTH{cin}}} + {{WIDTH{1'b0}}, cin};
   assign s     = sum_s[WIDTH-1:0];
   assign cout  = sum_s[WIDTH];

endmodule

module restoring_divider_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic             div0,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
   localparam logic [2:0]       CNT_LAST = 3'd7;

   state_t           state_r, state_nxt;
   logic [WIDTH-1:0] q_r, r_r, d_r;
   logic [2:0]       cnt_r;
   logic             busy_r, done_r, div0_r;
   logic [WIDTH-1:0] quot_r, rem_r;

   logic [WIDTH-1:0] q_nxt, r_nxt, d_nxt, quot_nxt, rem_nxt;
   logic [2:0]       cnt_nxt;
   logic             busy_nxt, done_nxt, div0_nxt;

   logic             hi_s, cout_s, accept_s, take_s, last_s;
   logic [WIDTH-1:0] rs_s, diff_s, q_step_s, r_step_s;

   // A bit shifted out of R means the partial remainder exceeds any divisor
   assign hi_s     = r_r[WIDTH-1];
   assign rs_s     = {r_r[WIDTH-2:0], q_r[WIDTH-1]};
   assign accept_s = hi_s | cout_s;
   assign q_step_s = {q_r[WIDTH-2:0], accept_s};
   assign r_step_s = accept_s ? diff_s : rs_s;
   assign last_s   = (cnt_r == CNT_LAST);
   // DONE with busy still high is the one-cycle divide-by-zero completion step
   assign take_s   = start & ~busy_r & ((state_r == IDLE) | (state_r == DONE));

   full_adder_subtrator #(.WIDTH(WIDTH)) u_addsub (
      .a    (rs_s),
      .b    (d_r),
      .cin  (1'b1),
      .s    (diff_s),
      .cout (cout_s)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt;
      end
   end

   // Next-state decode
   always_comb begin
      state_nxt = state_r;
      case (state_r)
         IDLE: begin
            if (take_s) begin
               state_nxt = (divisor == ZERO) ? DONE : RUN;
            end else begin
               state_nxt = IDLE;
            end
         end
         RUN: begin
            if (last_s) begin
               state_nxt = DONE;
            end else begin
               state_nxt = RUN;
            end
         end
         DONE: begin
            if (busy_r) begin
               state_nxt = DONE;
            end else if (take_s) begin
               state_nxt = (divisor == ZERO) ? RUN : RUN;
               if (divisor == ZERO) begin
                  state_nxt = DONE;
               end else begin
                  state_nxt = RUN;
               end
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Output and working-register next values
   always_comb begin
      q_nxt    = q_r;
      r_nxt    = r_r;
      d_nxt    = d_r;
      cnt_nxt  = cnt_r;
      busy_nxt = busy_r;
      done_nxt = 1'b0;
      div0_nxt = div0_r;
      quot_nxt = quot_r;
      rem_nxt  = rem_r;
      if (take_s) begin
         q_nxt    = dividend;
         d_nxt    = divisor;
         r_nxt    = ZERO;
         cnt_nxt  = 3'd0;
         busy_nxt = 1'b1;
      end else if (state_r == RUN) begin
         q_nxt   = q_step_s;
         r_nxt   = r_step_s;
         cnt_nxt = cnt_r + 3'd1;
         if (last_s) begin
            quot_nxt = q_step_s;
            rem_nxt  = r_step_s;
            div0_nxt = 1'b0;
            done_nxt = 1'b1;
            busy_nxt = 1'b0;
         end else begin
            done_nxt = 1'b0;
         end
      end else if ((state_r == DONE) && busy_r) begin
         quot_nxt = ALL_ONES;
         rem_nxt  = q_r;
         div0_nxt = 1'b1;
         done_nxt = 1'b1;
         busy_nxt = 1'b0;
      end else begin
         done_nxt = 1'b0;
      end
   end

   // Working and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_r    <= ZERO;
         r_r    <= ZERO;
         d_r    <= ZERO;
         cnt_r  <= 3'd0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         div0_r <= 1'b0;
         quot_r <= ZERO;
         rem_r  <= ZERO;
      end else begin
         q_r    <= q_nxt;
         r_r    <= r_nxt;
         d_r    <= d_nxt;
         cnt_r  <= cnt_nxt;
         busy_r <= busy_nxt;
         done_r <= done_nxt;
         div0_r <= div0_nxt;
         quot_r <= quot_nxt;
         rem_r  <= rem_nxt;
      end
   end

   assign busy      = busy_r;
   assign done      = done_r;
   assign div0      = div0_r;
   assign quotient  = quot_r;
   assign remainder = rem_r;

endmodule
